// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multi-cycle control unit sequencing PC, IR, register file,
// ULA and a variable-latency memory port through a req/ready handshake.
// Adds a memory-wait timeout trap and a retired-instruction counter.
module uc_multiciclo #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             WEMem,
    output logic             PC_load,
    output logic             IR_load,
    output logic             RF_load,
    output logic [1:0]       ULAop,
    output logic [1:0]       wb_sel,
    output logic [1:0]       pc_src,
    output logic             trap,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R     = 3'd0,
        CL_I     = 3'd1,
        CL_LOAD  = 3'd2,
        CL_STORE = 3'd3,
        CL_BEQ   = 3'd4,
        CL_JAL   = 3'd5,
        CL_JALR  = 3'd6
    } cls_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    cls_t        cls;
    logic [31:0] wait_cnt;
    logic        timeout_hit;

    // A wait that reaches its last allowed cycle without mem_ready traps;
    // mem_ready in that same cycle takes precedence.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = !mem_ready && (wait_cnt == (TIMEOUT - 1));
        end
    end

    // State sequencing, instruction-class latch, wait counter and retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cls      <= CL_R;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        state <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_DECODE: begin
                    state <= S_EXEC;
                    case (opcode)
                        7'b0110011: cls <= CL_R;
                        7'b0010011: cls <= CL_I;
                        7'b0000011: cls <= CL_LOAD;
                        7'b0100011: cls <= CL_STORE;
                        7'b1100011: cls <= CL_BEQ;
                        7'b1101111: cls <= CL_JAL;
                        7'b1100111: cls <= CL_JALR;
                        default:    state <= S_TRAP;
                    endcase
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    case (cls)
                        CL_R, CL_I:        state <= S_WB;
                        CL_LOAD, CL_STORE: state <= S_MEM;
                        default: begin
                            state   <= S_FETCH;
                            retired <= retired + CNT_ONE;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (cls == CL_STORE) begin
                            state   <= S_FETCH;
                            retired <= retired + CNT_ONE;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (timeout_hit) begin
                        state <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                    retired  <= retired + CNT_ONE;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end

    // Control strobes decoded from state, latched class, zero and mem_ready.
    always_comb begin
        mem_req = 1'b0;
        mem_sel = 1'b0;
        WEMem   = 1'b0;
        PC_load = 1'b0;
        IR_load = 1'b0;
        RF_load = 1'b0;
        ULAop   = 2'b00;
        wb_sel  = 2'b00;
        pc_src  = 2'b00;
        trap    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                IR_load = mem_ready;
            end
            S_EXEC: begin
                case (cls)
                    CL_R, CL_I: ULAop = 2'b10;
                    CL_BEQ: begin
                        ULAop   = 2'b01;
                        PC_load = 1'b1;
                        pc_src  = zero ? 2'b01 : 2'b00;
                    end
                    CL_JAL: begin
                        RF_load = 1'b1;
                        wb_sel  = 2'b10;
                        PC_load = 1'b1;
                        pc_src  = 2'b01;
                    end
                    CL_JALR: begin
                        RF_load = 1'b1;
                        wb_sel  = 2'b10;
                        PC_load = 1'b1;
                        pc_src  = 2'b10;
                    end
                    default: ULAop = 2'b00;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                if (cls == CL_STORE) begin
                    WEMem   = 1'b1;
                    PC_load = mem_ready;
                end
            end
            S_WB: begin
                RF_load = 1'b1;
                wb_sel  = (cls == CL_LOAD) ? 2'b01 : 2'b00;
                PC_load = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uc_multiciclo.sv
module tb_uc_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_sel, WEMem, PC_load, IR_load, RF_load, trap;
    logic [1:0]  ULAop, wb_sel, pc_src;
    logic [31:0] retired;
    logic [2:0]  state_dbg;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    uc_multiciclo #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel),
        .WEMem(WEMem), .PC_load(PC_load), .IR_load(IR_load),
        .RF_load(RF_load), .ULAop(ULAop), .wb_sel(wb_sel), .pc_src(pc_src),
        .trap(trap), .retired(retired), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, land 2 time units after the edge (inputs change here)
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
        step(); step(); #1;
        chk("rst_state", state_dbg, 3'd0);
        chk("rst_outs", {mem_req, mem_sel, WEMem, PC_load, IR_load, RF_load, ULAop, wb_sel, pc_src, trap}, '0);
        chk("rst_retired", retired, 0);

        // 1: R-type, memory always ready
        reset = 1'b1; #1;
        chk("idle_after_release", state_dbg, 3'd0);
        step(); #1;
        chk("r_fetch", state_dbg, 3'd1);
        chk("r_fetch_strobes", {mem_req, mem_sel, IR_load, RF_load}, 4'b1010);
        step(); #1;
        chk("r_decode", {state_dbg, RF_load}, {3'd2, 1'b0});
        step(); #1;
        chk("r_exec", {state_dbg, ULAop, RF_load, PC_load}, {3'd3, 2'b10, 1'b0, 1'b0});
        step(); #1;
        chk("r_wb", {state_dbg, RF_load, wb_sel, PC_load, pc_src}, {3'd5, 1'b1, 2'b00, 1'b1, 2'b00});
        chk("r_not_yet_retired", retired, 0);
        step(); #1;
        chk("r_back_fetch", state_dbg, 3'd1);
        chk("r_retired", retired, 1);

        // 2: LOAD with 3 wait cycles in MEM (ready arrives on the last allowed cycle)
        opcode = OP_LOAD;
        step(); #1;
        chk("ld_decode", state_dbg, 3'd2);
        step(); #1;
        chk("ld_exec", {state_dbg, ULAop}, {3'd3, 2'b00});
        step(); mem_ready = 1'b0; #1;
        chk("ld_mem1", {state_dbg, mem_req, mem_sel, WEMem, PC_load}, {3'd4, 1'b1, 1'b1, 1'b0, 1'b0});
        step(); #1;
        chk("ld_mem2", {state_dbg, mem_sel}, {3'd4, 1'b1});
        step(); #1;
        chk("ld_mem3", {state_dbg, mem_sel, WEMem}, {3'd4, 1'b1, 1'b0});
        step(); mem_ready = 1'b1; #1;
        chk("ld_mem4", {state_dbg, mem_sel, trap}, {3'd4, 1'b1, 1'b0});
        step(); #1;
        chk("ld_wb", {state_dbg, RF_load, wb_sel, PC_load}, {3'd5, 1'b1, 2'b01, 1'b1});
        step(); #1;
        chk("ld_retired", {state_dbg, retired}, {3'd1, 32'd2});

        // 3: BEQ taken, then not taken with an opcode change mid-flight
        opcode = OP_BEQ; zero = 1'b1;
        step(); step(); #1;
        chk("beq_t_exec", {state_dbg, ULAop, PC_load, pc_src, RF_load}, {3'd3, 2'b01, 1'b1, 2'b01, 1'b0});
        step(); #1;
        chk("beq_t_done", {state_dbg, retired}, {3'd1, 32'd3});
        zero = 1'b0;
        step(); #1;
        chk("beq_n_decode", state_dbg, 3'd2);
        step(); opcode = OP_R; #1;
        chk("beq_n_exec", {state_dbg, ULAop, PC_load, pc_src, RF_load}, {3'd3, 2'b01, 1'b1, 2'b00, 1'b0});
        step(); #1;
        chk("beq_n_done", {state_dbg, retired}, {3'd1, 32'd4});

        // 4: JALR and JAL
        opcode = OP_JALR;
        step(); step(); #1;
        chk("jalr_exec", {state_dbg, RF_load, wb_sel, pc_src, PC_load, ULAop}, {3'd3, 1'b1, 2'b10, 2'b10, 1'b1, 2'b00});
        step(); #1;
        chk("jalr_done", {state_dbg, retired}, {3'd1, 32'd5});
        opcode = OP_JAL;
        step(); step(); #1;
        chk("jal_exec", {state_dbg, RF_load, wb_sel, pc_src, PC_load}, {3'd3, 1'b1, 2'b10, 2'b01, 1'b1});
        step(); #1;
        chk("jal_done", retired, 5'd6);

        // STORE, memory ready immediately
        opcode = OP_STORE;
        step(); step(); #1;
        chk("st_exec", {state_dbg, ULAop, WEMem}, {3'd3, 2'b00, 1'b0});
        step(); #1;
        chk("st_mem", {state_dbg, mem_req, mem_sel, WEMem, PC_load, pc_src, RF_load}, {3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        step(); #1;
        chk("st_done", {state_dbg, retired}, {3'd1, 32'd7});

        // 6a: illegal opcode traps from DECODE, trap is sticky
        opcode = OP_BAD;
        step(); step(); #1;
        chk("bad_trap", {state_dbg, trap, mem_req, PC_load, RF_load}, {3'd6, 1'b1, 1'b0, 1'b0, 1'b0});
        mem_ready = 1'b0;
        step(); mem_ready = 1'b1; step(); #1;
        chk("bad_sticky", {state_dbg, trap, retired}, {3'd6, 1'b1, 32'd7});
        reset = 1'b0; #1;
        chk("bad_async_rst", {state_dbg, trap, retired}, {3'd0, 1'b0, 32'd0});

        // 5: FETCH timeout after 4 cycles without ready
        opcode = OP_R;
        step(); reset = 1'b1;
        step(); mem_ready = 1'b0; #1;
        chk("to_fetch1", state_dbg, 3'd1);
        step(); step(); step(); #1;
        chk("to_fetch4", {state_dbg, trap, IR_load}, {3'd1, 1'b0, 1'b0});
        step(); #1;
        chk("to_trap", {state_dbg, trap}, {3'd6, 1'b1});
        mem_ready = 1'b1;
        step(); #1;
        chk("to_sticky", {state_dbg, trap}, {3'd6, 1'b1});
        reset = 1'b0;
        step(); reset = 1'b1;
        step(); mem_ready = 1'b0;
        step(); step(); step(); mem_ready = 1'b1; #1;
        chk("to_ready_wins", {state_dbg, IR_load}, {3'd1, 1'b1});
        step(); #1;
        chk("to_no_trap", {state_dbg, trap}, {3'd2, 1'b0});

        // 6b: reset in MEM during a waiting STORE drops WEMem immediately
        opcode = OP_STORE;
        step(); mem_ready = 1'b0; step(); #1;
        chk("st_wait", {state_dbg, WEMem, PC_load}, {3'd4, 1'b1, 1'b0});
        reset = 1'b0; #1;
        chk("st_rst_async", {state_dbg, WEMem, mem_req, retired}, {3'd0, 1'b0, 1'b0, 32'd0});
        step(); reset = 1'b1; mem_ready = 1'b1;
        step(); #1;
        chk("st_restart", state_dbg, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
